// File: rtl/half_subtractor_if.sv
// half_subtractor_if: operand/result bundle for the lane-parallel half subtractor
interface half_subtractor_if #(parameter int WIDTH = 1);
    logic             in_valid;
    logic             sticky_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] difference;
    logic [WIDTH-1:0] borrow;
    logic             any_borrow;
    logic             borrow_seen;
    modport master (
        output in_valid, sticky_clr, a, b,
        input  out_valid, difference, borrow, any_borrow, borrow_seen
    );
    modport slave (
        input  in_valid, sticky_clr, a, b,
        output out_valid, difference, borrow, any_borrow, borrow_seen
    );
endinterface

// File: rtl/half_subtractor.sv
// half_subtractor: registered lane-parallel half subtractor with sticky borrow flag
module half_subtractor #(
    parameter int WIDTH = 1
) (
    input logic              clk,
    input logic              rst,
    half_subtractor_if.slave bus
);
    logic [WIDTH-1:0] diff_q, diff_d, borrow_q, borrow_d;
    logic             valid_q, any_q, any_d, seen_q, seen_d;
    // Results hold while idle; in_valid gates the operands so unknowns never leak in.
    always_comb begin
        diff_d   = bus.in_valid ? bus.a ^ bus.b : diff_q;
        borrow_d = bus.in_valid ? ~bus.a & bus.b : borrow_q;
        any_d    = |borrow_d;
        seen_d   = (bus.in_valid && |(~bus.a & bus.b)) || (seen_q && !bus.sticky_clr);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= '0;
            any_q    <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            valid_q  <= bus.in_valid;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            any_q    <= any_d;
            seen_q   <= seen_d;
        end
    end
    assign bus.out_valid   = valid_q;
    assign bus.difference  = diff_q;
    assign bus.borrow      = borrow_q;
    assign bus.any_borrow  = any_q;
    assign bus.borrow_seen = seen_q;
endmodule

// File: tb/tb_half_subtractor.sv
// tb_half_subtractor: directed checks of 1-lane and 8-lane half subtractors
module tb_half_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    half_subtractor_if #(.WIDTH(1)) if1 ();
    half_subtractor_if #(.WIDTH(8)) if8 ();

    half_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    half_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic clr);
        if1.in_valid   = v;
        if1.a          = a;
        if1.b          = b;
        if1.sticky_clr = clr;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b);
        if8.in_valid   = v;
        if8.a          = a;
        if8.b          = b;
        if8.sticky_clr = 1'b0;
    endtask

    initial begin
        logic [1:0] vec [4];
        logic [1:0] exp1 [4];
        vec  = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp1 = '{2'b00, 2'b11, 2'b10, 2'b00};
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        drive8(1'b1, 8'hFF, 8'hFF);
        repeat (2) cyc();
        check("rst1_valid", 64'(if1.out_valid), 64'd0);
        check("rst1_diff", 64'(if1.difference), 64'd0);
        check("rst1_borrow", 64'(if1.borrow), 64'd0);
        check("rst1_any", 64'(if1.any_borrow), 64'd0);
        check("rst1_seen", 64'(if1.borrow_seen), 64'd0);
        check("rst8_valid", 64'(if8.out_valid), 64'd0);
        check("rst8_diff", 64'(if8.difference), 64'd0);
        check("rst8_borrow", 64'(if8.borrow), 64'd0);
        rst = 1'b0;
        drive8(1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, vec[i][1], vec[i][0], 1'b0);
            cyc();
            check("tt_diff", 64'(if1.difference), 64'(exp1[i][1]));
            check("tt_borrow", 64'(if1.borrow), 64'(exp1[i][0]));
            check("tt_valid", 64'(if1.out_valid), 64'd1);
        end
        drive1(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, i[0], ~i[0], 1'b0);
            cyc();
            check("hold_valid", 64'(if1.out_valid), 64'd0);
            check("hold_diff", 64'(if1.difference), 64'd1);
            check("hold_borrow", 64'(if1.borrow), 64'd1);
            check("hold_any", 64'(if1.any_borrow), 64'd1);
        end
        drive8(1'b1, 8'hA5, 8'h3C);
        cyc();
        check("w8a_diff", 64'(if8.difference), 64'h99);
        check("w8a_borrow", 64'(if8.borrow), 64'h18);
        check("w8a_any", 64'(if8.any_borrow), 64'd1);
        check("w8a_seen", 64'(if8.borrow_seen), 64'd1);
        drive8(1'b1, 8'hFF, 8'h0F);
        cyc();
        check("w8b_diff", 64'(if8.difference), 64'hF0);
        check("w8b_borrow", 64'(if8.borrow), 64'h00);
        check("w8b_any", 64'(if8.any_borrow), 64'd0);
        check("w8b_valid", 64'(if8.out_valid), 64'd1);
        drive8(1'b0, 8'h00, 8'h00);
        cyc();
        check("w8_idle_valid", 64'(if8.out_valid), 64'd0);
        check("w8_idle_diff", 64'(if8.difference), 64'hF0);
        drive1(1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        check("sticky_init_clr", 64'(if1.borrow_seen), 64'd0);
        drive1(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        check("sticky_set", 64'(if1.borrow_seen), 64'd1);
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        check("sticky_keep", 64'(if1.borrow_seen), 64'd1);
        check("sticky_keep_any", 64'(if1.any_borrow), 64'd0);
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        check("sticky_set_wins", 64'(if1.borrow_seen), 64'd1);
        drive1(1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        check("sticky_clr", 64'(if1.borrow_seen), 64'd0);
        drive1(1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        check("sticky_idle", 64'(if1.borrow_seen), 64'd0);
        drive1(1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        check("mid_rst_valid", 64'(if1.out_valid), 64'd0);
        check("mid_rst_diff", 64'(if1.difference), 64'd0);
        check("mid_rst_borrow", 64'(if1.borrow), 64'd0);
        check("mid_rst_seen", 64'(if1.borrow_seen), 64'd0);
        rst = 1'b0;
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        check("post_rst_diff", 64'(if1.difference), 64'd1);
        check("post_rst_borrow", 64'(if1.borrow), 64'd0);
        check("post_rst_valid", 64'(if1.out_valid), 64'd1);
        check("post_rst_seen", 64'(if1.borrow_seen), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
